// File: rtl/store_wb_buffer_pkg.sv
// Shared system definitions for the store write-back buffer: data width,
// default depth and the retired-store packet.
package store_wb_buffer_pkg;

  localparam int SYS_XLEN      = 32;
  localparam int SWB_DEPTH_DEF = 8;

  typedef struct packed {
    logic                ready;
    logic [SYS_XLEN-1:0] addr;
    logic [SYS_XLEN-1:0] data;
    logic [3:0]          bytes;
  } SQ_ENTRY_PACKET;

  localparam SQ_ENTRY_PACKET SQ_EMPTY = '{
    ready: 1'b0,
    addr:  {SYS_XLEN{1'b0}},
    data:  {SYS_XLEN{1'b0}},
    bytes: 4'b0000
  };

endpackage

// File: rtl/store_wb_buffer_if.sv
// Bus bundle between retire logic / dcache / load unit and the store buffer.
interface store_wb_buffer_if
  import store_wb_buffer_pkg::*;
#(
  parameter int SWB_DEPTH = SWB_DEPTH_DEF,
  parameter int SWB_IDX_W = $clog2(SWB_DEPTH)
);

  SQ_ENTRY_PACKET [2:0]            ret_entries;
  logic [SWB_IDX_W:0]              swb_free_cnt;
  logic                            dc_req_valid;
  logic [SYS_XLEN-1:0]             dc_req_addr;
  logic [SYS_XLEN-1:0]             dc_req_data;
  logic [3:0]                      dc_req_bytes;
  logic                            dc_req_ack;
  logic [1:0][SYS_XLEN-1:0]        ld_addr;
  logic [1:0][3:0]                 ld_fwd_bytes;
  logic [1:0][SYS_XLEN-1:0]        ld_fwd_data;
  logic                            swb_empty;
  logic                            swb_overflow;

  modport master (
    output ret_entries, dc_req_ack, ld_addr,
    input  swb_free_cnt, dc_req_valid, dc_req_addr, dc_req_data, dc_req_bytes,
    input  ld_fwd_bytes, ld_fwd_data, swb_empty, swb_overflow
  );

  modport slave (
    input  ret_entries, dc_req_ack, ld_addr,
    output swb_free_cnt, dc_req_valid, dc_req_addr, dc_req_data, dc_req_bytes,
    output ld_fwd_bytes, ld_fwd_data, swb_empty, swb_overflow
  );

endinterface

// File: rtl/store_wb_buffer_swb_byte_fwd.sv
// Per-load-port byte forwarder: walks entries from oldest (head) to youngest
// so the youngest matching writer of each byte wins, independent of wrap.
module swb_byte_fwd
  import store_wb_buffer_pkg::*;
#(
  parameter int SWB_DEPTH = SWB_DEPTH_DEF,
  parameter int SWB_IDX_W = $clog2(SWB_DEPTH)
) (
  input  logic [SWB_DEPTH-1:0]               i_valid,
  input  logic [SWB_DEPTH-1:0][SYS_XLEN-1:0] i_addr,
  input  logic [SWB_DEPTH-1:0][SYS_XLEN-1:0] i_data,
  input  logic [SWB_DEPTH-1:0][3:0]          i_bytes,
  input  logic [SWB_IDX_W-1:0]               i_head,
  input  logic [SYS_XLEN-1:0]                i_ld_addr,
  output logic [3:0]                         o_fwd_bytes,
  output logic [SYS_XLEN-1:0]                o_fwd_data
);

  // Age-ordered scan: later (younger) hits overwrite earlier ones.
  always_comb begin
    logic [SWB_IDX_W-1:0] w_idx;
    logic                 w_hit;
    o_fwd_bytes = 4'b0000;
    o_fwd_data  = {SYS_XLEN{1'b0}};
    w_idx       = i_head;
    w_hit       = 1'b0;
    for (int a = 0; a < SWB_DEPTH; a++) begin
      w_idx = i_head + SWB_IDX_W'(a);
      for (int b = 0; b < 4; b++) begin
        w_hit = i_valid[w_idx] && (i_addr[w_idx] == i_ld_addr) && i_bytes[w_idx][b];
        o_fwd_bytes[b]      = w_hit ? 1'b1 : o_fwd_bytes[b];
        o_fwd_data[8*b +: 8] = w_hit ? i_data[w_idx][8*b +: 8] : o_fwd_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/store_wb_buffer.sv
// Circular store write-back buffer: compacts up to three retired stores per
// cycle, drains the head to the dcache and forwards bytes to two load ports.
module store_wb_buffer
  import store_wb_buffer_pkg::*;
#(
  parameter int SWB_DEPTH = SWB_DEPTH_DEF,
  parameter int SWB_IDX_W = $clog2(SWB_DEPTH)
) (
  input logic              clk,
  input logic              rst_n,
  store_wb_buffer_if.slave swb
);

  logic [SWB_IDX_W-1:0]               r_head;
  logic [SWB_IDX_W-1:0]               r_tail;
  logic [SWB_IDX_W:0]                 r_count;
  logic                               r_overflow;
  logic [SWB_DEPTH-1:0]               r_valid;
  logic [SWB_DEPTH-1:0][SYS_XLEN-1:0] r_addr;
  logic [SWB_DEPTH-1:0][SYS_XLEN-1:0] r_data;
  logic [SWB_DEPTH-1:0][3:0]          r_bytes;

  logic                 w_empty;
  logic                 w_pop;
  logic [SWB_IDX_W:0]   w_free;
  logic [SWB_IDX_W:0]   w_cap;
  logic [1:0]           w_n_acc;
  logic                 w_drop;
  logic [2:0]           w_wr_en;
  SQ_ENTRY_PACKET       w_wr_pkt [3];
  logic [SWB_IDX_W-1:0] w_slot [3];
  logic [3:0]           w_fb0, w_fb1;
  logic [SYS_XLEN-1:0]  w_fd0, w_fd1;

  assign w_empty = (r_count == {(SWB_IDX_W+1){1'b0}});
  assign w_pop   = swb.dc_req_ack && !w_empty;
  assign w_free  = (SWB_IDX_W+1)'(SWB_DEPTH) - r_count;
  // A popping slot is reusable in the same cycle, so a full buffer still takes one.
  assign w_cap   = w_free + (SWB_IDX_W+1)'(w_pop);

  // Compact valid retired stores oldest-first into consecutive tail slots.
  always_comb begin
    w_n_acc = 2'd0;
    w_drop  = 1'b0;
    w_wr_en = 3'b000;
    for (int j = 0; j < 3; j++) begin
      w_wr_pkt[j] = SQ_EMPTY;
      w_slot[j]   = r_tail + SWB_IDX_W'(j);
    end
    for (int k = 2; k >= 0; k--) begin
      if (swb.ret_entries[k].ready) begin
        if ({{(SWB_IDX_W-1){1'b0}}, w_n_acc} < w_cap) begin
          case (w_n_acc)
            2'd0:    begin w_wr_en[0] = 1'b1; w_wr_pkt[0] = swb.ret_entries[k]; end
            2'd1:    begin w_wr_en[1] = 1'b1; w_wr_pkt[1] = swb.ret_entries[k]; end
            default: begin w_wr_en[2] = 1'b1; w_wr_pkt[2] = swb.ret_entries[k]; end
          endcase
          w_n_acc = w_n_acc + 2'd1;
        end else begin
          w_drop = 1'b1;
        end
      end else begin
        w_drop = w_drop;
      end
    end
  end

  // Pointer, count, entry storage and sticky overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= {SWB_IDX_W{1'b0}};
      r_tail     <= {SWB_IDX_W{1'b0}};
      r_count    <= {(SWB_IDX_W+1){1'b0}};
      r_overflow <= 1'b0;
      r_valid    <= {SWB_DEPTH{1'b0}};
      r_addr     <= {(SWB_DEPTH*SYS_XLEN){1'b0}};
      r_data     <= {(SWB_DEPTH*SYS_XLEN){1'b0}};
      r_bytes    <= {(SWB_DEPTH*4){1'b0}};
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + SWB_IDX_W'(1);
      end
      for (int j = 0; j < 3; j++) begin
        if (w_wr_en[j]) begin
          r_valid[w_slot[j]] <= w_wr_pkt[j].ready;
          r_addr[w_slot[j]]  <= w_wr_pkt[j].addr;
          r_data[w_slot[j]]  <= w_wr_pkt[j].data;
          r_bytes[w_slot[j]] <= w_wr_pkt[j].bytes;
        end
      end
      r_tail  <= r_tail + SWB_IDX_W'(w_n_acc);
      r_count <= r_count + (SWB_IDX_W+1)'(w_n_acc) - (SWB_IDX_W+1)'(w_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  swb_byte_fwd #(.SWB_DEPTH(SWB_DEPTH), .SWB_IDX_W(SWB_IDX_W)) u_fwd0 (
    .i_valid(r_valid), .i_addr(r_addr), .i_data(r_data), .i_bytes(r_bytes),
    .i_head(r_head), .i_ld_addr(swb.ld_addr[0]),
    .o_fwd_bytes(w_fb0), .o_fwd_data(w_fd0)
  );

  swb_byte_fwd #(.SWB_DEPTH(SWB_DEPTH), .SWB_IDX_W(SWB_IDX_W)) u_fwd1 (
    .i_valid(r_valid), .i_addr(r_addr), .i_data(r_data), .i_bytes(r_bytes),
    .i_head(r_head), .i_ld_addr(swb.ld_addr[1]),
    .o_fwd_bytes(w_fb1), .o_fwd_data(w_fd1)
  );

  assign swb.swb_free_cnt = w_free;
  assign swb.swb_empty    = w_empty;
  assign swb.swb_overflow = r_overflow;
  assign swb.dc_req_valid = !w_empty;
  assign swb.dc_req_addr  = w_empty ? {SYS_XLEN{1'b0}} : r_addr[r_head];
  assign swb.dc_req_data  = w_empty ? {SYS_XLEN{1'b0}} : r_data[r_head];
  assign swb.dc_req_bytes = w_empty ? 4'b0000 : r_bytes[r_head];
  assign swb.ld_fwd_bytes = {w_fb1, w_fb0};
  assign swb.ld_fwd_data  = {w_fd1, w_fd0};

endmodule

// File: tb/tb_store_wb_buffer.sv
// Self-checking bench for store_wb_buffer: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_store_wb_buffer;
  import store_wb_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;

  store_wb_buffer_if #(.SWB_DEPTH(DEPTH)) swb_if ();
  store_wb_buffer #(.SWB_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .swb(swb_if));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bytes;
  } ent_t;

  typedef struct {
    logic [2:0]  mask;
    logic [31:0] a2, a1, a0;
    logic        ack;
    int          exp_cnt;
    logic [31:0] exp_addr;
  } vec_t;

  ent_t        mq[$];
  bit          m_ovf;
  int          checks = 0;
  int          failures = 0;
  logic [2:0]  in_mask;
  ent_t        in_e [3];
  logic        in_ack;
  logic [31:0] in_la [2];
  vec_t        tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    ent_t e;
    e.addr = a; e.data = d; e.bytes = b;
    return e;
  endfunction

  task automatic idle();
    in_mask = 3'b000; in_ack = 1'b0;
    for (int k = 0; k < 3; k++) in_e[k] = mk(32'h0, 32'h0, 4'h0);
    in_la[0] = 32'h0; in_la[1] = 32'h0;
  endtask

  task automatic apply();
    for (int k = 0; k < 3; k++) begin
      swb_if.ret_entries[k].ready = in_mask[k];
      swb_if.ret_entries[k].addr  = in_e[k].addr;
      swb_if.ret_entries[k].data  = in_e[k].data;
      swb_if.ret_entries[k].bytes = in_e[k].bytes;
    end
    swb_if.dc_req_ack = in_ack;
    swb_if.ld_addr[0] = in_la[0];
    swb_if.ld_addr[1] = in_la[1];
  endtask

  // Expected outputs derived from the queue: front = oldest, back = youngest.
  task automatic model_check();
    logic [3:0]  fb;
    logic [31:0] fd;
    chk("free_cnt", swb_if.swb_free_cnt, 64'(DEPTH - mq.size()));
    chk("empty", swb_if.swb_empty, 64'(mq.size() == 0));
    chk("dc_valid", swb_if.dc_req_valid, 64'(mq.size() != 0));
    chk("overflow", swb_if.swb_overflow, 64'(m_ovf));
    if (mq.size() > 0) begin
      chk("dc_addr", swb_if.dc_req_addr, mq[0].addr);
      chk("dc_data", swb_if.dc_req_data, mq[0].data);
      chk("dc_bytes", swb_if.dc_req_bytes, mq[0].bytes);
    end
    for (int p = 0; p < 2; p++) begin
      fb = 4'h0; fd = 32'h0;
      foreach (mq[i]) begin
        if (mq[i].addr == in_la[p]) begin
          for (int b = 0; b < 4; b++) begin
            if (mq[i].bytes[b]) begin
              fb[b] = 1'b1;
              fd[8*b +: 8] = mq[i].data[8*b +: 8];
            end
          end
        end
      end
      chk("fwd_bytes", swb_if.ld_fwd_bytes[p], fb);
      chk("fwd_data", swb_if.ld_fwd_data[p], fd);
    end
  endtask

  task automatic step();
    apply();
    #1;
    model_check();
  endtask

  task automatic tick();
    int cap;
    bit pop;
    @(posedge clk);
    pop = in_ack && (mq.size() > 0);
    cap = DEPTH - mq.size() + (pop ? 1 : 0);
    if (pop) void'(mq.pop_front());
    for (int k = 2; k >= 0; k--) begin
      if (in_mask[k]) begin
        if (cap > 0) begin mq.push_back(in_e[k]); cap--; end
        else m_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_out(input string tag);
    chk({tag, "_dc_valid"}, swb_if.dc_req_valid, 64'd0);
    chk({tag, "_empty"}, swb_if.swb_empty, 64'd1);
    chk({tag, "_free"}, swb_if.swb_free_cnt, 64'd8);
    chk({tag, "_fwd_bytes"}, swb_if.ld_fwd_bytes, 64'd0);
    chk({tag, "_fwd_data"}, swb_if.ld_fwd_data, 64'd0);
    chk({tag, "_dc_addr"}, swb_if.dc_req_addr, 64'd0);
    chk({tag, "_dc_data"}, swb_if.dc_req_data, 64'd0);
    chk({tag, "_dc_bytes"}, swb_if.dc_req_bytes, 64'd0);
    chk({tag, "_overflow"}, swb_if.swb_overflow, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    apply();
    #1;
    check_reset_out("rst");
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nstores;
    logic [3:0] rb;

    // Basic enqueue and ack-hold table
    tbl[0] = '{mask: 3'b111, a2: 32'h100, a1: 32'h104, a0: 32'h108, ack: 1'b0, exp_cnt: 0, exp_addr: 32'h0};
    tbl[1] = '{mask: 3'b000, a2: 32'h0, a1: 32'h0, a0: 32'h0, ack: 1'b0, exp_cnt: 3, exp_addr: 32'h100};
    for (int i = 2; i < 6; i++) tbl[i] = tbl[1];
    tbl[6] = '{mask: 3'b000, a2: 32'h0, a1: 32'h0, a0: 32'h0, ack: 1'b1, exp_cnt: 3, exp_addr: 32'h100};
    tbl[7] = '{mask: 3'b000, a2: 32'h0, a1: 32'h0, a0: 32'h0, ack: 1'b0, exp_cnt: 2, exp_addr: 32'h104};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      in_mask = tbl[i].mask;
      in_ack  = tbl[i].ack;
      in_e[2] = mk(tbl[i].a2, tbl[i].a2 + 32'h1000_0000, 4'hF);
      in_e[1] = mk(tbl[i].a1, tbl[i].a1 + 32'h1000_0000, 4'hF);
      in_e[0] = mk(tbl[i].a0, tbl[i].a0 + 32'h1000_0000, 4'hF);
      step();
      chk("tbl_free", swb_if.swb_free_cnt, 64'(DEPTH - tbl[i].exp_cnt));
      chk("tbl_valid", swb_if.dc_req_valid, 64'(tbl[i].exp_cnt != 0));
      if (tbl[i].exp_cnt != 0) chk("tbl_dc_addr", swb_if.dc_req_addr, tbl[i].exp_addr);
      tick();
    end

    // Byte-granular youngest-match forwarding
    do_reset();
    idle(); in_mask = 3'b100; in_e[2] = mk(32'h200, 32'h0000_00AA, 4'b0011); in_la[0] = 32'h200;
    step(); tick();
    idle(); in_mask = 3'b100; in_e[2] = mk(32'h200, 32'h0000_00BB, 4'b0001); in_la[0] = 32'h200;
    step();
    chk("fwd_same_cycle_bytes", swb_if.ld_fwd_bytes[0], 64'h3);
    chk("fwd_same_cycle_data", swb_if.ld_fwd_data[0], 64'hAA);
    tick();
    idle(); in_la[0] = 32'h200; in_la[1] = 32'h204;
    step();
    chk("fwd_young_bytes", swb_if.ld_fwd_bytes[0], 64'h3);
    chk("fwd_young_data", swb_if.ld_fwd_data[0], 64'hBB);
    chk("fwd_miss_bytes", swb_if.ld_fwd_bytes[1], 64'h0);
    tick();

    // Overflow on a nearly full buffer, then full buffer with pop
    do_reset();
    n = 0;
    for (int c = 0; c < 3; c++) begin
      idle();
      in_mask = (c == 2) ? 3'b100 : 3'b111;
      for (int k = 2; k >= 0; k--) begin
        in_e[k] = mk(32'h400 + 32'(4 * n), 32'hC0DE_0000 + 32'(n), 4'hF);
        if (in_mask[k]) n++;
      end
      step(); tick();
    end
    idle(); in_mask = 3'b101;
    in_e[2] = mk(32'h41C, 32'h1111_1111, 4'hF); in_e[0] = mk(32'h420, 32'h2222_2222, 4'hF);
    step();
    chk("ovf_pre_free", swb_if.swb_free_cnt, 64'd1);
    tick();
    idle(); in_mask = 3'b001; in_ack = 1'b1; in_e[0] = mk(32'h424, 32'h3333_3333, 4'hF);
    step();
    chk("ovf_full_free", swb_if.swb_free_cnt, 64'd0);
    chk("ovf_sticky", swb_if.swb_overflow, 64'd1);
    tick();
    idle();
    step();
    chk("full_pop_free", swb_if.swb_free_cnt, 64'd0);
    chk("full_pop_head", swb_if.dc_req_addr, 64'h404);
    tick();

    // Asynchronous reset while draining with ack asserted
    do_reset();
    idle(); in_mask = 3'b111;
    in_e[2] = mk(32'h500, 32'hA0, 4'hF); in_e[1] = mk(32'h504, 32'hA1, 4'hF); in_e[0] = mk(32'h508, 32'hA2, 4'hF);
    step(); tick();
    idle(); in_mask = 3'b100; in_e[2] = mk(32'h50C, 32'hA3, 4'hF);
    step(); tick();
    idle(); in_ack = 1'b1; in_la[0] = 32'h500;
    step();
    chk("pre_rst_free", swb_if.swb_free_cnt, 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_out("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_reset_out("async_rst_hold");
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    idle();
    step(); tick();

    // Randomized traffic with wrap-around, retirement capped by free count
    do_reset();
    nstores = 0;
    for (int c = 0; c < 400; c++) begin
      idle();
      in_mask = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        if (($countones(in_mask) > DEPTH - mq.size()) && in_mask[k]) in_mask[k] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        rb = 4'($urandom_range(1, 15));
        in_e[k] = mk(32'h300 + 32'(4 * $urandom_range(0, 3)), $urandom, rb);
      end
      nstores += $countones(in_mask);
      in_ack = 1'($urandom_range(0, 1));
      in_la[0] = 32'h300 + 32'(4 * $urandom_range(0, 3));
      in_la[1] = 32'h300 + 32'(4 * $urandom_range(0, 3));
      step(); tick();
    end
    chk("rand_enough_stores", 64'(nstores >= 20), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
